// File: rtl/traffic_light_pkg.sv
// Shared encodings for the parametrised intersection controller: FSM states,
// the 3-bit debug phase code and the {red,yellow,green} lamp patterns.
package traffic_light_pkg;

  typedef enum logic [3:0] {
    NS_GREEN   = 4'd0,
    NS_YELLOW  = 4'd1,
    ALL_RED_A  = 4'd2,
    EW_GREEN   = 4'd3,
    EW_YELLOW  = 4'd4,
    ALL_RED_B  = 4'd5,
    PED_WALK_A = 4'd6,
    PED_WALK_B = 4'd7,
    FLASH      = 4'd8
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Nine states do not fit the 3-bit debug bus, so both walk phases share code 6.
  function automatic logic [2:0] phase_code(state_e s);
    logic [2:0] code;
    case (s)
      NS_GREEN:               code = 3'd0;
      NS_YELLOW:              code = 3'd1;
      ALL_RED_A:              code = 3'd2;
      EW_GREEN:               code = 3'd3;
      EW_YELLOW:              code = 3'd4;
      ALL_RED_B:              code = 3'd5;
      PED_WALK_A, PED_WALK_B: code = 3'd6;
      FLASH:                  code = 3'd7;
      default:                code = 3'd5;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks, restartable via clear.
module tick_prescaler
  import traffic_light_pkg::*;
#(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(CLK_DIV - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Two-road intersection controller with per-phase durations, a latched
// pedestrian walk phase and a flashing-yellow maintenance mode.
module traffic_light_ctrl_param
  import traffic_light_pkg::*;
#(
  parameter int CLK_DIV  = 50000000,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 6,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flash_mode,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             ped_walk,
  output logic             ped_pending,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] tick_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             blink_q, blink_d;
  logic             pend_q, pend_d;
  logic             tick;
  logic             presc_clear;
  logic             in_walk;
  logic             walk_req;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (presc_clear),
    .tick    (tick)
  );

  function automatic logic [CNT_W-1:0] last_tick(state_e s);
    int dur;
    case (s)
      NS_GREEN, EW_GREEN:     dur = GREEN_T;
      NS_YELLOW, EW_YELLOW:   dur = YELLOW_T;
      ALL_RED_A, ALL_RED_B:   dur = ALLRED_T;
      PED_WALK_A, PED_WALK_B: dur = PED_T;
      default:                dur = 1;
    endcase
    return CNT_W'(dur - 1);
  endfunction

  function automatic state_e advance(state_e s, logic want_walk);
    state_e n;
    case (s)
      NS_GREEN:   n = NS_YELLOW;
      NS_YELLOW:  n = ALL_RED_A;
      ALL_RED_A:  n = want_walk ? PED_WALK_A : EW_GREEN;
      EW_GREEN:   n = EW_YELLOW;
      EW_YELLOW:  n = ALL_RED_B;
      ALL_RED_B:  n = want_walk ? PED_WALK_B : NS_GREEN;
      PED_WALK_A: n = EW_GREEN;
      PED_WALK_B: n = NS_GREEN;
      default:    n = ALL_RED_B;
    endcase
    return n;
  endfunction

  assign in_walk  = (state_q == PED_WALK_A) || (state_q == PED_WALK_B);
  // A request arriving on the very cycle of the all-red exit still wins the walk.
  assign walk_req = pend_q | ped_req;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    blink_d     = blink_q;
    pend_d      = pend_q;
    presc_clear = 1'b0;

    if (ped_req && !in_walk) begin
      pend_d = 1'b1;
    end

    if (flash_mode) begin
      if (state_q != FLASH) begin
        state_d     = FLASH;
        timer_d     = '0;
        blink_d     = 1'b1;
        presc_clear = 1'b1;
      end else if (tick) begin
        blink_d = ~blink_q;
      end
    end else if (state_q == FLASH) begin
      state_d     = ALL_RED_B;
      timer_d     = '0;
      presc_clear = 1'b1;
    end else if (tick) begin
      if (timer_q == last_tick(state_q)) begin
        timer_d = '0;
        state_d = advance(state_q, walk_req);
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (((state_d == PED_WALK_A) || (state_d == PED_WALK_B)) && !in_walk) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ALL_RED_B;
      timer_q <= '0;
      blink_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    ped_walk = 1'b0;
    case (state_q)
      NS_GREEN:               ns_light = LAMP_GRN;
      NS_YELLOW:              ns_light = LAMP_YEL;
      EW_GREEN:               ew_light = LAMP_GRN;
      EW_YELLOW:              ew_light = LAMP_YEL;
      PED_WALK_A, PED_WALK_B: ped_walk = 1'b1;
      FLASH: begin
        ns_light = blink_q ? LAMP_YEL : LAMP_OFF;
        ew_light = blink_q ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign ped_pending = pend_q;
  assign phase       = phase_code(state_q);
  assign tick_count  = timer_q;

endmodule
